// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolver: registered taken/not-taken decision, one-cycle PC redirect,
// and a multi-cycle IF/ID flush. Optional statistics counters behind BRANCH_RESOLVE_STATS_EN.
module branch_resolve #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic              br_is_jump,
  input  logic              br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              res_valid,
  output logic              res_taken,
  output logic              addr_err,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stat_total,
  output logic [CNT_W-1:0]  stat_taken
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       accept, take, misaligned, go_flush;

  assign br_ready   = (state == IDLE);
  assign flush      = (state == FLUSH);
  assign accept     = br_valid & br_ready & ~stall;
  assign take       = br_is_jump | br_cond;
  assign misaligned = |br_target[1:0];
  assign go_flush   = accept & take & ~misaligned;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (go_flush) begin
          state_nx = FLUSH;
          cnt_nx   = 4'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        // Counter freezes under stall, so stalled cycles extend the flush.
        if (!stall) begin
          if (cnt == 4'd1) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
      res_valid   <= 1'b0;
      res_taken   <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      redirect  <= go_flush;
      res_valid <= accept;
      res_taken <= accept & take;
      addr_err  <= accept & take & misaligned;
      if (go_flush) redirect_pc <= br_target;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else if (stat_clr) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else if (res_valid) begin
      if (stat_total != '1) stat_total <= stat_total + 1'b1;
      if (res_taken && stat_taken != '1) stat_taken <= stat_taken + 1'b1;
    end
  end
`else
  logic stat_clr_unused;
  assign stat_clr_unused = stat_clr;
  assign stat_total      = '0;
  assign stat_taken      = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed, table-driven bench for branch_resolve; stats checks adapt to BRANCH_RESOLVE_STATS_EN.
module tb_branch_resolve;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 2;

  logic              clock = 1'b0;
  logic              reset_n, stall, br_valid, br_ready, br_is_jump, br_cond;
  logic [ADDR_W-1:0] br_target, redirect_pc;
  logic              redirect, flush, res_valid, res_taken, addr_err, stat_clr;
  logic [CNT_W-1:0]  stat_total, stat_taken;

  int total = 0;
  int bad   = 0;

  branch_resolve #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .br_valid(br_valid), .br_ready(br_ready), .br_is_jump(br_is_jump),
    .br_cond(br_cond), .br_target(br_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .res_valid(res_valid), .res_taken(res_taken), .addr_err(addr_err),
    .stat_clr(stat_clr), .stat_total(stat_total), .stat_taken(stat_taken)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v, j, c, s;
    logic [31:0] tgt;
    logic        e_ready, e_rv, e_rt, e_redir, e_aerr, e_flush;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic j, input logic c, input logic s,
                       input logic [31:0] tgt);
    br_valid   = v;
    br_is_jump = j;
    br_cond    = c;
    stall      = s;
    br_target  = tgt;
  endtask

  int flush_cnt, redir_cnt, rv_cnt;

  initial begin
    reset_n = 1'b0;
    stat_clr = 1'b0;
    drive(0, 0, 0, 0, 32'h0);

    vecs[0]  = '{1,0,1,0, 32'h0040_0020, 0,1,1,1,0,1, 32'h0040_0020};
    vecs[1]  = '{0,0,0,0, 32'h0,         0,0,0,0,0,1, 32'h0040_0020};
    vecs[2]  = '{0,0,0,0, 32'h0,         1,0,0,0,0,0, 32'h0040_0020};
    vecs[3]  = '{1,0,0,0, 32'h0000_0100, 1,1,0,0,0,0, 32'h0040_0020};
    vecs[4]  = '{1,0,0,0, 32'h0000_0104, 1,1,0,0,0,0, 32'h0040_0020};
    vecs[5]  = '{1,1,0,0, 32'h0040_0022, 1,1,1,0,1,0, 32'h0040_0020};
    vecs[6]  = '{1,1,0,0, 32'h0040_0040, 0,1,1,1,0,1, 32'h0040_0040};
    vecs[7]  = '{1,0,1,0, 32'h0000_0200, 0,0,0,0,0,1, 32'h0040_0040};
    vecs[8]  = '{1,0,1,1, 32'h0000_0200, 0,0,0,0,0,1, 32'h0040_0040};
    vecs[9]  = '{0,0,0,0, 32'h0,         1,0,0,0,0,0, 32'h0040_0040};
    vecs[10] = '{1,0,1,1, 32'h0000_0300, 1,0,0,0,0,0, 32'h0040_0040};
    vecs[11] = '{1,0,1,0, 32'h0000_0303, 1,1,1,0,1,0, 32'h0040_0040};
    vecs[12] = '{0,0,0,0, 32'h0,         1,0,0,0,0,0, 32'h0040_0040};

    // Reset state
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    #1;
    chk("rst_ready", 32'(br_ready), 1);
    chk("rst_redirect", 32'(redirect), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_addr_err", 32'(addr_err), 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_stat_total", 32'(stat_total), 0);
    chk("rst_stat_taken", 32'(stat_taken), 0);

    // Table-driven sequence
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v, vecs[i].j, vecs[i].c, vecs[i].s, vecs[i].tgt);
      tick();
      chk($sformatf("v%0d_ready", i), 32'(br_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_res_valid", i), 32'(res_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk($sformatf("v%0d_res_taken", i), 32'(res_taken), 32'(vecs[i].e_rt));
      chk($sformatf("v%0d_redirect", i), 32'(redirect), 32'(vecs[i].e_redir));
      chk($sformatf("v%0d_addr_err", i), 32'(addr_err), 32'(vecs[i].e_aerr));
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
      chk($sformatf("v%0d_pc", i), redirect_pc, vecs[i].e_pc);
    end

    // Stall mid-flush: one unstalled flush cycle, three stalled, then drain; br_valid held high
    drive(1, 0, 1, 0, 32'h0040_1000);
    flush_cnt = 0; redir_cnt = 0; rv_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      stall = (i >= 2 && i <= 4);
      tick();
      if (flush) flush_cnt++;
      if (redirect) redir_cnt++;
      if (res_valid) rv_cnt++;
      if (!flush && i > 0) break;
    end
    drive(0, 0, 0, 0, 32'h0);
    chk("stall_flush_cycles", 32'(flush_cnt), 5);
    chk("stall_redirects", 32'(redir_cnt), 1);
    chk("stall_res_valids", 32'(rv_cnt), 1);
    chk("stall_pc", redirect_pc, 32'h0040_1000);
    chk("stall_ready_after", 32'(br_ready), 1);
    tick();
    chk("stall_no_late_accept", 32'(res_valid), 0);

    // Asynchronous reset mid-flush
    drive(1, 1, 0, 0, 32'h0040_2000);
    tick();
    drive(0, 0, 0, 0, 32'h0);
    chk("arst_pre_flush", 32'(flush), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_flush", 32'(flush), 0);
    chk("arst_ready", 32'(br_ready), 1);
    chk("arst_redirect", 32'(redirect), 0);
    chk("arst_pc", redirect_pc, 0);
    #2 reset_n = 1'b1;
    tick();
    chk("arst_idle_flush", 32'(flush), 0);

    // Statistics
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    drive(1, 0, 0, 0, 32'h0000_0100);
    tick();
    drive(1, 1, 0, 0, 32'h0000_0002);
    tick();
    drive(0, 0, 0, 0, 32'h0);
    tick();
    tick();
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("stat_total_2", 32'(stat_total), 2);
    chk("stat_taken_1", 32'(stat_taken), 1);
`else
    chk("stat_total_off", 32'(stat_total), 0);
    chk("stat_taken_off", 32'(stat_taken), 0);
`endif
    drive(1, 1, 0, 0, 32'h0000_0002);
    repeat (5) tick();
    drive(0, 0, 0, 0, 32'h0);
    tick();
    tick();
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("stat_total_sat", 32'(stat_total), 3);
    chk("stat_taken_sat", 32'(stat_taken), 3);
`else
    chk("stat_total_off2", 32'(stat_total), 0);
    chk("stat_taken_off2", 32'(stat_taken), 0);
`endif
    drive(1, 0, 1, 0, 32'h0000_0002);
    tick();
    drive(0, 0, 0, 0, 32'h0);
    chk("clr_res_valid", 32'(res_valid), 1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    tick();
    chk("clr_stat_total", 32'(stat_total), 0);
    chk("clr_stat_taken", 32'(stat_taken), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Resolves branches and jumps in the EX stage, directly downstream of the 32-bit comparator.
- Consumes the comparator result (compout) together with the branch descriptor.
- Decides taken/not-taken and issues a one-cycle PC redirect.
- Drives a multi-cycle flush to squash younger instructions in IF/ID, back-pressuring new branches until the flush completes.

Parameters:
- ADDR_W, 32, width of PC and target addresses.
- FLUSH_CYCLES, 2, number of cycles flush is held after a taken redirect; legal range 1..15.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  pipeline freeze; blocks acceptance and holds the flush counter.
- br_valid  input  1  a branch/jump descriptor is present.
- br_ready  output  1  block can accept a descriptor; high only in IDLE.
- br_is_jump  input  1  unconditional jump; compout is ignored.
- br_cond  input  1  comparator result (compout) for a conditional branch.
- br_target  input  ADDR_W  branch/jump target address.
- redirect  output  1  one-cycle pulse requesting a PC load.
- redirect_pc  output  ADDR_W  PC value to load; meaningful while redirect is high.
- flush  output  1  squash younger instructions.
- res_valid  output  1  one-cycle pulse reporting the resolution outcome.
- res_taken  output  1  outcome flag, qualified by res_valid.
- addr_err  output  1  one-cycle pulse: a taken target is misaligned.
- stat_clr  input  1  synchronous clear of the statistics counters.
- stat_total  output  CNT_W  count of resolved branches.
- stat_taken  output  CNT_W  count of taken branches.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, counter=0.
  - All outputs are 0 (redirect_pc=0, stats=0) except br_ready, which is 1 in IDLE.
  - Reset mid-FLUSH aborts the flush immediately.
- Accept condition: br_valid & br_ready & ~stall. A descriptor presented while not accepted is ignored; upstream holds it.
- Decision: take = br_is_jump | br_cond.
- Latency: all results are registered and appear on the cycle after acceptance.
  - res_valid=1 and res_taken=take for exactly one cycle.
- Not taken: no redirect, no flush, state stays IDLE, back-to-back acceptance allowed.
- Taken with br_target[1:0] != 0:
  - addr_err pulses one cycle; res_valid pulses with res_taken=1.
  - No redirect, no flush, state stays IDLE.
- Taken with an aligned target:
  - Next cycle: redirect=1 for one cycle, redirect_pc=br_target.
  - State goes to FLUSH, counter=FLUSH_CYCLES.
- States: IDLE, FLUSH.
  - IDLE: br_ready=1, flush=0.
  - FLUSH: br_ready=0, flush=1.
    - Counter decrements on each cycle with stall=0 and holds when stall=1.
    - When the counter is 1 and stall=0, the next state is IDLE.
  - Result: flush is high for exactly FLUSH_CYCLES unstalled cycles, plus any stalled cycles.
- redirect never re-pulses during FLUSH, including across stalls.
- redirect_pc holds its last value when redirect is low.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- Defined:
  - stat_total increments on every res_valid.
  - stat_taken increments on every res_valid with res_taken=1.
  - Both counters saturate at 2^CNT_W-1, never wrapping.
  - stat_clr zeroes both; if stat_clr and an increment coincide, clear wins.
- Not defined: ports remain present; stat_total and stat_taken are tied to 0 and stat_clr is ignored.

Test Plan:
- Reset check: reset_n low, then release → br_ready=1; redirect, flush, res_valid, addr_err all 0; stats 0.
- Conditional taken: br_cond=1, br_target=0x00400020, FLUSH_CYCLES=2 → next cycle redirect=1 with redirect_pc=0x00400020, res_taken=1; flush high 2 cycles; br_ready low 2 cycles, then high.
- Not-taken back-to-back: br_cond=0 on consecutive cycles → res_valid each cycle after accept, res_taken=0, no redirect or flush, br_ready stays 1.
- Stall during flush: stall=1 for 3 cycles mid-FLUSH → flush high 2+3=5 cycles total, exactly one redirect pulse; br_valid during FLUSH not accepted.
- Misaligned jump: br_is_jump=1, br_target=0x00400022 → addr_err pulse, res_taken=1, no redirect, no flush; reset_n pulsed low mid-flush aborts to IDLE with flush=0 immediately.
- Stats (macro defined, CNT_W=2): 5 taken branches → stat_total=3 (saturated), stat_taken=3; stat_clr coinciding with a res_valid → both counters 0.
